// File: rtl/amp_mem.sv
`default_nettype none
// ============================================================================
// Module      : amp_mem
// Description : Unified instruction/data memory for the multicycle AMP core.
//               Serves one request at a time over a valid/ready channel and
//               answers with a registered one-cycle response pulse after
//               LATENCY wait states. Byte-enabled writes; misaligned or
//               out-of-range accesses are flagged and never touch memory.
// Revision    : 1.0 - initial release
// ============================================================================
module amp_mem #(
  parameter int DEPTH   = 1024,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
);

  localparam int NBYTES = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                accept;
  logic                go_resp;

  // Request captured at acceptance
  logic                lat_write;
  logic [31:0]         lat_addr;
  logic [WIDTH-1:0]    lat_wdata;
  logic [NBYTES-1:0]   lat_be;

  // Request seen by the memory on the edge entering RESP. With zero wait
  // states that edge is the acceptance edge itself, so the live inputs are
  // used; otherwise the captured copy is used.
  logic                acc_write;
  logic [31:0]         acc_addr;
  logic [WIDTH-1:0]    acc_wdata;
  logic [NBYTES-1:0]   acc_be;
  logic                acc_err;
  logic [ADDR_W-1:0]   acc_idx;
  logic                mem_we;

  logic [WIDTH-1:0]    mem [DEPTH];

  // State register; reset forces IDLE and drops any pending request
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, acceptance and ready generation
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt = RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the effective request and classify it
  always_comb begin
    acc_write = (state == IDLE) ? req_write : lat_write;
    acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    acc_be    = (state == IDLE) ? req_be    : lat_be;
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    acc_idx   = acc_addr[ADDR_W+1:2];
    mem_we    = reset && go_resp && acc_write && !acc_err;
  end

  // Request capture, wait counter and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= go_resp;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (go_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_write) ? '0 : mem[acc_idx];
      end
    end
  end

  // Byte-lane write commit; contents survive reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (mem_we && acc_be[b]) begin
        mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/amp_mem.md
# amp_mem

Parametrised unified instruction/data memory for the multicycle AMP core, replacing the fixed single-cycle RAMs. It serves one request at a time over a valid/ready request channel and returns a one-cycle response pulse after a configurable number of wait states. It supports byte-enabled writes and flags misaligned or out-of-range accesses. The core's control FSM stalls in its fetch/memory states until the response pulse arrives.

## Interface
- DEPTH, 1024: number of words; power of two, ≥ 2.
- WIDTH, 32: word width in bits; multiple of 8.
- LATENCY, 2: wait states between acceptance and response; range 0..15.
- ADDR_W, $clog2(DEPTH): word-index width (derived; do not override).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  in  WIDTH  write data.
- req_be  in  WIDTH/8  byte enables for writes; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errored accesses.
- rsp_err  out  1  access was misaligned or out of range; qualified by rsp_valid.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch write, address, wdata and be; load the wait counter with LATENCY.
  - Go to WAIT if LATENCY > 0, else go to RESP.
- WAIT:
  - req_ready = 0; decrement the counter.
  - When the counter is 1, the next edge goes to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle; req_ready = 0.
  - Return to IDLE on the next edge.
- Error check on the latched request: misaligned when addr[1:0] ≠ 0; out of range when addr[31:ADDR_W+2] ≠ 0.
  - An errored access does not touch memory; rsp_err = 1, rsp_rdata = 0.
  - An errored access has the same latency as a normal one.
- Writes:
  - Commit on the edge entering RESP; only bytes with be[i] = 1 are updated.
  - rsp_rdata = 0 for writes.
  - be = 0 is legal: no change, normal response.
- Reads sample memory on the edge entering RESP. A read issued after a write to the same word returns the merged new value.
- Inputs presented outside IDLE are ignored and not queued.
- Reset (reset = 0 at an edge):
  - State becomes IDLE; rsp_valid, rsp_err and rsp_rdata become 0; the counter becomes 0.
  - A pending, uncommitted write is discarded and no response is issued.
  - Memory contents are not cleared.
  - While reset is held, req_ready = 1 but requests are not accepted.
- rsp_rdata and rsp_err are registered and hold their values after rsp_valid drops, until the next response or reset.

## Timing
- Acceptance edge is E0. rsp_valid is high in the cycle after edge E0+LATENCY, i.e. a latency of LATENCY+1 cycles.
- req_ready rises again in the cycle after the RESP cycle.
- Maximum throughput: one request every LATENCY+2 cycles.
- LATENCY = 0: rsp_valid is high in the cycle directly after acceptance; the next acceptance is possible one cycle later.
- All outputs are registered except req_ready, which is decoded from the state register. There is no combinational path from req_* to rsp_*.

## Test plan
- Reset with LATENCY = 2: hold reset = 0 for 3 cycles with req_valid = 1. Required: no acceptance, rsp_valid = 0, rsp_rdata = 0, and req_ready = 1 after release.
- Write then read, LATENCY = 2:
  - Write 0xDEADBEEF to 0x10 with be = 0xF. Required: rsp_valid exactly 3 cycles after acceptance, rsp_err = 0.
  - Then read 0x10. Required: rsp_rdata = 0xDEADBEEF, 3 cycles after acceptance.
- Byte enables:
  - Word 0x20 holds 0x11223344; write 0xAABBCCDD with be = 0b0101.
  - Read 0x20. Required: 0x11BB33DD.
- Errors:
  - Read 0x13. Required: rsp_err = 1, rsp_rdata = 0.
  - Write to 0x1000 with DEPTH = 1024. Required: rsp_err = 1, and word 0 is unchanged afterwards.
- Back-to-back with LATENCY = 0, req_valid held high with 4 reads: required one acceptance every 2 cycles and each rsp_valid one cycle after its acceptance. With LATENCY = 15: required response at +16 cycles.
- Reset mid-write:
  - Accept a write of 0x55 to 0x40 with LATENCY = 4; assert reset 2 cycles later.
  - Required: no rsp_valid, and a subsequent read of 0x40 returns the prior contents.
